// File: rtl/pc_fetch.sv
// Program counter and single-outstanding instruction fetch sequencer.
// Fetches one word per instruction and hands it to decode; the PC advances only on handoff.
module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] npc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] ins,
  output logic        ins_valid,
  input  logic        ins_ready,
  output logic [31:0] ins_cnt,
  output logic        addr_err
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] REQ  = 3'd1;
  localparam logic [2:0] WAIT = 3'd2;
  localparam logic [2:0] HOLD = 3'd3;
  localparam logic [2:0] ERR  = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ins_q, ins_d;
  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ins_d   = ins_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (imem_gnt) state_d = WAIT;
      end
      WAIT: begin
        if (imem_rvalid) begin
          ins_d   = imem_rdata;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (ins_ready) begin
          cnt_d   = cnt_q + 32'd1;
          pc_d    = npc;
          state_d = (npc[1:0] == 2'b00) ? REQ : ERR;
        end
      end
      ERR:     state_d = ERR;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      ins_q   <= 32'd0;
      cnt_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ins_q   <= ins_d;
      cnt_q   <= cnt_d;
    end
  end

  // Handshake outputs are pure state decodes so no input can reach them combinationally.
  assign imem_req  = (state_q == REQ);
  assign ins_valid = (state_q == HOLD);
  assign addr_err  = (state_q == ERR);
  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign ins       = ins_q;
  assign ins_cnt   = cnt_q;

endmodule
